// File: rtl/regfile_pkg.sv
// Shared widths and types for the architectural register file.
// Holds default geometry plus word and address typedefs.
// Imported by the register file top and its popcount helper.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEPTH      = 1 << DEF_ADDR_W;

  typedef logic [DEF_DATA_W-1:0] word_t;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_popcount.sv
// Combinational population count of the busy vector.
// Latency: 0 cycles, pure combinational.
// No backpressure; output follows the input vector.
module regfile_popcount
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [(1<<ADDR_W)-1:0] vec,
  output logic [ADDR_W:0]        count
);

  // Sum every bit of the vector into an ADDR_W+1 wide counter.
  always_comb begin
    count = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      count = count + {{ADDR_W{1'b0}}, vec[i]};
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with two forwarding read ports, one write port and a busy scoreboard.
// Latency: reads 0 cycles (with same-cycle write forwarding), writes and busy updates 1 edge.
// No handshakes; every input is sampled on every rising edge.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_count
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic [ADDR_W:0]   pop_nxt;
  logic              wr_ok;
  logic              issue_ok;

  // Register 0 is hardwired (read 0, never written or busy) when ZERO_REG is set.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr_ok    = wr_en && !is_zero(wr_addr);
  assign issue_ok = issue_en && !is_zero(issue_addr);

  // Read ports: hardwired zero, else forward the in-flight writeback, else stored data.
  always_comb begin
    rd_data_a = mem[rd_addr_a];
    rd_data_b = mem[rd_addr_b];
    rd_busy_a = busy[rd_addr_a] && !(wr_en && wr_addr == rd_addr_a);
    rd_busy_b = busy[rd_addr_b] && !(wr_en && wr_addr == rd_addr_b);
    if (is_zero(rd_addr_a)) begin
      rd_data_a = '0;
      rd_busy_a = 1'b0;
    end else if (wr_en && wr_addr == rd_addr_a) begin
      rd_data_a = wr_data;
    end
    if (is_zero(rd_addr_b)) begin
      rd_data_b = '0;
      rd_busy_b = 1'b0;
    end else if (wr_en && wr_addr == rd_addr_b) begin
      rd_data_b = wr_data;
    end
  end

  // Next busy vector: flush wins outright; otherwise writeback clears, then issue sets.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_ok)    busy_nxt[wr_addr]    = 1'b0;
      if (issue_ok) busy_nxt[issue_addr] = 1'b1;
    end
  end

  regfile_popcount #(.ADDR_W(ADDR_W)) u_popcount (
    .vec   (busy_nxt),
    .count (pop_nxt)
  );

  // Scoreboard and its count move together on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= pop_nxt;
    end
  end

  // Data storage; a flush does not block writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule
